sprite_anim_renderer: RTL and testbench

Parametrised, animated sprite renderer for the VGA pixel path. It generates sprite ROM addresses from the current draw coordinates and a latched sprite position, and sequences through NUM_FRAMES animation frames on vertical-blank ticks. Mirroring and a transparent palette index are supported. Pixel colour comes from an external palette, and the block emits registered RGB plus an opaque flag so the compositor can layer it over background and other fighters.

---
 rtl/sprite_anim_renderer.sv | 155 +++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer.sv
// Animated sprite renderer: hit-test and ROM addressing against a frame-latched sprite
// position, a vblank-driven frame sequencer, and a two-stage pipeline to registered RGB.
module sprite_anim_renderer #(
    parameter  int SPR_W           = 64,
    parameter  int SPR_H           = 96,
    parameter  int NUM_FRAMES      = 4,
    parameter  int FRAME_HOLD      = 6,
    parameter  int IDX_W           = 4,
    parameter  int TRANSPARENT_IDX = 0,
    localparam int ADDR_W          = $clog2(SPR_W * SPR_H * NUM_FRAMES),
    localparam int FRAME_W         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               blank,
    input  logic               frame_tick,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               flip,
    input  logic               anim_start,
    input  logic               loop_en,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pal_index,
    input  logic [3:0]         pal_red,
    input  logic [3:0]         pal_green,
    input  logic [3:0]         pal_blue,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               opaque,
    output logic [FRAME_W-1:0] frame_idx,
    output logic               anim_busy,
    output logic               anim_done
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t              state_q;
    logic [FRAME_W-1:0]  frame_idx_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                anim_busy_q;
    logic                anim_done_q;

    logic [9:0]          sx_q, sx_d, sy_q, sy_d;
    logic                flip_q, flip_d;
    logic [10:0]         dx, dy, lx;
    logic                hit;
    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
    logic                hit_d1_q, hit_d1_d;
    logic [3:0]          red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic                opaque_q, opaque_d;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
        rom_address_d = '0;
        // Position and mirroring only change on the vblank tick so a sprite never tears mid-frame.
        sx_d   = frame_tick ? sprite_x : sx_q;
        sy_d   = frame_tick ? sprite_y : sy_q;
        flip_d = frame_tick ? flip     : flip_q;

        // 11-bit differences: a borrow into bit 10 means the pixel is left of/above the sprite.
        dx  = {1'b0, draw_x} - {1'b0, sx_q};
        dy  = {1'b0, draw_y} - {1'b0, sy_q};
        hit = blank && (draw_x >= sx_q) && (draw_y >= sy_q)
              && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
        lx  = flip_q ? (11'(SPR_W - 1) - dx) : dx;

        if (hit) begin
            rom_address_d = ADDR_W'(frame_idx_q) * ADDR_W'(SPR_W * SPR_H)
                          + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(lx);
        end
        hit_d1_d = hit;

        // Stage 2: rom_q belongs to the address registered one cycle earlier, alongside hit_d1_q.
        opaque_d = hit_d1_q && (rom_q != IDX_W'(TRANSPARENT_IDX));
        red_d    = opaque_d ? pal_red   : 4'd0;
        green_d  = opaque_d ? pal_green : 4'd0;
        blue_d   = opaque_d ? pal_blue  : 4'd0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q          <= '0;
            sy_q          <= '0;
            flip_q        <= 1'b0;
            rom_address_q <= '0;
            hit_d1_q      <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            opaque_q      <= 1'b0;
        end else begin
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            flip_q        <= flip_d;
            rom_address_q <= rom_address_d;
            hit_d1_q      <= hit_d1_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            opaque_q      <= opaque_d;
        end
    end

    // Animation sequencer; anim_start has priority and swallows a coincident tick.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            frame_idx_q <= '0;
            hold_cnt_q  <= '0;
            anim_busy_q <= 1'b0;
            anim_done_q <= 1'b0;
        end else begin
            anim_done_q <= 1'b0;
            if (anim_start) begin
                state_q     <= S_PLAY;
                frame_idx_q <= '0;
                hold_cnt_q  <= '0;
                anim_busy_q <= 1'b1;
            end else if (state_q == S_PLAY && frame_tick) begin
                if (hold_cnt_q == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold_cnt_q <= '0;
                    if (frame_idx_q != FRAME_W'(NUM_FRAMES - 1)) begin
                        frame_idx_q <= frame_idx_q + 1'b1;
                    end else if (loop_en) begin
                        frame_idx_q <= '0;
                    end else begin
                        state_q     <= S_DONE;
                        anim_busy_q <= 1'b0;
                        anim_done_q <= 1'b1;
                    end
                end else begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end
        end
    end

    assign rom_address = rom_address_q;
    assign pal_index   = rom_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign opaque      = opaque_q;
    assign frame_idx   = frame_idx_q;
    assign anim_busy   = anim_busy_q;
    assign anim_done   = anim_done_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Self-checking bench for sprite_anim_renderer: an external ROM/palette model, a
// cycle-level reference model compared every cycle, and hand-computed directed checks.
module tb_sprite_anim_renderer;

    localparam int SPR_W      = 64;
    localparam int SPR_H      = 96;
    localparam int NUM_FRAMES = 4;
    localparam int FRAME_HOLD = 6;
    localparam int IDX_W      = 4;
    localparam int ADDR_W     = 15;
    localparam int FRAME_W    = 2;
    localparam int RUN_TICKS  = NUM_FRAMES * FRAME_HOLD;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic [9:0]        draw_x, draw_y, sprite_x, sprite_y;
    logic              blank, frame_tick, flip, anim_start, loop_en;
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q = '0;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red, pal_green, pal_blue;
    logic [3:0]        red, green, blue;
    logic              opaque;
    logic [FRAME_W-1:0] frame_idx;
    logic              anim_busy, anim_done;

    int n_vec = 0;
    int n_err = 0;

    sprite_anim_renderer #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES),
        .FRAME_HOLD(FRAME_HOLD), .IDX_W(IDX_W), .TRANSPARENT_IDX(0)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .blank(blank), .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .flip(flip), .anim_start(anim_start), .loop_en(loop_en),
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .opaque(opaque),
        .frame_idx(frame_idx), .anim_busy(anim_busy), .anim_done(anim_done)
    );

    always #5 vga_clk = ~vga_clk;

    // Sprite ROM contents: address 0 holds 5, everything else its low nibble (so 64, 6144 are transparent).
    function automatic logic [3:0] rom_fn(int a);
        if (a == 0) return 4'd5;
        return 4'(a % 16);
    endfunction

    function automatic logic [3:0] pr(logic [3:0] i);
        return (i == 4'd5) ? 4'hF : i;
    endfunction
    function automatic logic [3:0] pg(logic [3:0] i);
        return (i == 4'd5) ? 4'h0 : 4'(15 - int'(i));
    endfunction
    function automatic logic [3:0] pb(logic [3:0] i);
        return (i == 4'd5) ? 4'h0 : 4'((int'(i) * 3) % 16);
    endfunction

    always @(negedge vga_clk) rom_q = rom_fn(int'(rom_address));
    assign pal_red   = pr(pal_index);
    assign pal_green = pg(pal_index);
    assign pal_blue  = pb(pal_index);

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: latched position, tick count since start, mode 0 idle / 1 play / 2 done.
    int m_sx, m_sy, m_mode, m_ticks;
    bit m_flip;
    int e_addr, e_r, e_g, e_b;
    bit e_hit1, e_opq, e_done;

    function automatic int m_frame();
        if (m_mode == 1) return (m_ticks / FRAME_HOLD) % NUM_FRAMES;
        if (m_mode == 2) return NUM_FRAMES - 1;
        return 0;
    endfunction

    always @(posedge vga_clk) begin
        int dxi, dyi, lx, addr;
        bit hit;
        logic [3:0] pix;
        if (!reset_n) begin
            m_sx = 0; m_sy = 0; m_flip = 0; m_mode = 0; m_ticks = 0;
            e_addr = 0; e_hit1 = 0; e_opq = 0; e_r = 0; e_g = 0; e_b = 0; e_done = 0;
        end else begin
            dxi  = int'(draw_x) - m_sx;
            dyi  = int'(draw_y) - m_sy;
            hit  = blank && dxi >= 0 && dxi < SPR_W && dyi >= 0 && dyi < SPR_H;
            lx   = m_flip ? SPR_W - 1 - dxi : dxi;
            addr = hit ? m_frame() * SPR_W * SPR_H + dyi * SPR_W + lx : 0;
            pix   = rom_fn(e_addr);
            e_opq = e_hit1 && pix != 4'd0;
            e_r   = e_opq ? int'(pr(pix)) : 0;
            e_g   = e_opq ? int'(pg(pix)) : 0;
            e_b   = e_opq ? int'(pb(pix)) : 0;
            e_addr = addr;
            e_hit1 = hit;
            if (frame_tick) begin
                m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_flip = flip;
            end
            e_done = 0;
            if (anim_start) begin
                m_mode = 1; m_ticks = 0;
            end else if (m_mode == 1 && frame_tick) begin
                m_ticks++;
                if (!loop_en && m_ticks % RUN_TICKS == 0) begin
                    m_mode = 2; e_done = 1;
                end
            end
        end
        #1;
        check("mdl_rom_address", int'(rom_address), e_addr);
        check("mdl_red",         int'(red),         e_r);
        check("mdl_green",       int'(green),       e_g);
        check("mdl_blue",        int'(blue),        e_b);
        check("mdl_opaque",      int'(opaque),      int'(e_opq));
        check("mdl_frame_idx",   int'(frame_idx),   m_frame());
        check("mdl_anim_busy",   int'(anim_busy),   int'(m_mode == 1));
        check("mdl_anim_done",   int'(anim_done),   int'(e_done));
        check("mdl_pal_index",   int'(pal_index),   int'(rom_q));
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge vga_clk);
        #2;
    endtask

    task automatic set_draw(input int x, input int y, input bit b);
        draw_x = 10'(x); draw_y = 10'(y); blank = b;
    endtask

    task automatic tick;
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
    endtask

    initial begin
        int lit;
        reset_n = 1'b0;
        sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0;
        set_draw(100, 50, 1'b1);
        frame_tick = 1'b1; anim_start = 1'b0; loop_en = 1'b0;
        step(3);
        check("rst_rom_address", int'(rom_address), 0);
        check("rst_rgb",         int'({red, green, blue}), 0);
        check("rst_opaque",      int'(opaque), 0);
        check("rst_frame_busy",  int'({frame_idx, anim_busy, anim_done}), 0);

        // Release, latch (100,50) on a tick, then measure latency of pixel (100,50).
        reset_n = 1'b1;
        step();
        frame_tick = 1'b0;
        set_draw(0, 0, 1'b0);
        step(2);
        set_draw(100, 50, 1'b1);
        step();
        check("lat_cycle1_opaque", int'(opaque), 0);
        set_draw(0, 0, 1'b0);
        step();
        check("lat_cycle2_red",    int'(red), 15);
        check("lat_cycle2_opaque", int'(opaque), 1);
        check("lat_cycle2_green",  int'(green), 0);

        // Mirroring.
        flip = 1'b1; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        set_draw(100, 51, 1'b1);
        step();
        check("flip1_addr", int'(rom_address), 127);
        flip = 1'b0; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        step();
        check("flip0_addr", int'(rom_address), 64);
        step();
        check("transp_opaque", int'(opaque), 0);
        check("transp_red",    int'(red), 0);

        // Clipping, blanking and the far corner of the box.
        set_draw(164, 50, 1'b1);
        step();
        check("clip_right_addr", int'(rom_address), 0);
        step();
        check("clip_right_opaque", int'(opaque), 0);
        set_draw(101, 50, 1'b0);
        step();
        check("blank_addr", int'(rom_address), 0);
        step();
        check("blank_rgb", int'({red, green, blue, opaque}), 0);
        set_draw(163, 145, 1'b1);
        step();
        check("corner_addr", int'(rom_address), 6143);
        set_draw(163, 146, 1'b1);
        step();
        check("below_addr", int'(rom_address), 0);

        // Non-looping animation.
        set_draw(100, 50, 1'b1);
        anim_start = 1'b1; step(); anim_start = 1'b0;
        check("start_busy", int'(anim_busy), 1);
        check("start_frame", int'(frame_idx), 0);
        for (int t = 1; t <= RUN_TICKS; t++) begin
            frame_tick = 1'b1; step();
            if (t == RUN_TICKS) begin
                check("done_pulse", int'(anim_done), 1);
                check("done_busy",  int'(anim_busy), 0);
                check("done_frame", int'(frame_idx), 3);
            end
            frame_tick = 1'b0; step();
            if (t == RUN_TICKS) check("done_pulse_end", int'(anim_done), 0);
            lit = -1;
            case (t)
                5: lit = 0; 6: lit = 1; 12: lit = 2; 18: lit = 3; 23: lit = 3;
                default: ;
            endcase
            if (lit >= 0) check($sformatf("nl_frame_t%0d", t), int'(frame_idx), lit);
            if (t == 6) check("frame1_pixel_addr", int'(rom_address), 6144);
        end
        tick();
        check("done_holds_frame", int'(frame_idx), 3);

        // Looping animation and restart mid frame 2.
        loop_en = 1'b1;
        anim_start = 1'b1; step(); anim_start = 1'b0;
        for (int t = 1; t <= RUN_TICKS; t++) tick();
        check("loop_wrap_frame", int'(frame_idx), 0);
        check("loop_wrap_busy",  int'(anim_busy), 1);
        for (int t = 1; t <= 15; t++) tick();
        check("loop_mid2_frame", int'(frame_idx), 2);
        anim_start = 1'b1; frame_tick = 1'b1; step();
        anim_start = 1'b0; frame_tick = 1'b0; step();
        check("restart_frame", int'(frame_idx), 0);
        check("restart_busy",  int'(anim_busy), 1);
        for (int t = 1; t <= 5; t++) tick();
        check("restart_hold5_frame", int'(frame_idx), 0);
        tick();
        check("restart_hold6_frame", int'(frame_idx), 1);

        // Shadow latching: the new sprite_x takes effect only after a tick.
        sprite_x = 10'd200;
        set_draw(100, 50, 1'b1);
        step();
        check("shadow_old_hit", int'(rom_address), 6144);
        set_draw(200, 50, 1'b1);
        step();
        check("shadow_new_miss", int'(rom_address), 0);
        tick();
        check("shadow_new_hit", int'(rom_address), 6144);
        set_draw(100, 50, 1'b1);
        step();
        check("shadow_old_miss", int'(rom_address), 0);

        // Clipping at the 1023 edge, both orientations (model-checked).
        sprite_x = 10'd1000; sprite_y = 10'd1000;
        for (int f = 0; f < 2; f++) begin
            flip = 1'(f);
            tick();
            set_draw(1023, 1023, 1'b1); step();
            set_draw(999, 1000, 1'b1);  step();
            set_draw(1000, 999, 1'b1);  step();
            set_draw(1000, 1000, 1'b1); step();
            set_draw(1010, 1020, 1'b1); step(3);
        end

        // Asynchronous reset in the middle of a line.
        set_draw(1010, 1010, 1'b1);
        step(2);
        #4;
        reset_n = 1'b0;
        #1;
        check("async_rst_addr",   int'(rom_address), 0);
        check("async_rst_opaque", int'(opaque), 0);
        check("async_rst_anim",   int'({frame_idx, anim_busy}), 0);
        step();
        reset_n = 1'b1;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
